// File: rtl/mod_swapchain.sv
// Segment switch controller: decides when the modulation sampler changes its read segment and counts loops.
// Build option MOD_SWAPCHAIN_GPIO_EN adds the GPIO_IN synchroniser and the GPIO (0x02) transition mode.

module mod_swapchain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        UPDATE,
    input  logic        REQ_RD_SEGMENT,
    input  logic [7:0]  TRANSITION_MODE,
    input  logic [63:0] TRANSITION_VALUE,
    input  logic [31:0] REP,
    input  logic [63:0] SYS_TIME,
    input  logic        LOOP_END,
    input  logic [3:0]  GPIO_IN,
    output logic        SEGMENT,
    output logic        TRANSITION,
    output logic        STOP,
    output logic        REJECT
);

    localparam logic [7:0]  MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0]  MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0]  MODE_GPIO      = 8'h02;
    localparam logic [7:0]  MODE_IMMEDIATE = 8'hFF;
    localparam logic [31:0] REP_INFINITE   = 32'hFFFF_FFFF;

`ifdef MOD_SWAPCHAIN_GPIO_EN
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_IDX  = 2'd1,
        WAIT_TIME = 2'd2,
        WAIT_GPIO = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_IDX  = 2'd1,
        WAIT_TIME = 2'd2
    } state_t;
`endif

    function automatic logic mode_valid(input logic [7:0] mode);
        case (mode)
            MODE_SYNC_IDX, MODE_SYS_TIME, MODE_IMMEDIATE: mode_valid = 1'b1;
`ifdef MOD_SWAPCHAIN_GPIO_EN
            MODE_GPIO:                                    mode_valid = 1'b1;
`endif
            default:                                      mode_valid = 1'b0;
        endcase
    endfunction

    function automatic state_t mode_state(input logic [7:0] mode);
        case (mode)
            MODE_SYS_TIME: mode_state = WAIT_TIME;
`ifdef MOD_SWAPCHAIN_GPIO_EN
            MODE_GPIO:     mode_state = WAIT_GPIO;
`endif
            default:       mode_state = WAIT_IDX;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        seg_q, trans_q, stop_q, reject_q;
    logic [31:0] rep_q, cnt_q;
    logic        pend_seg_q, pend_seg_d;
    logic [63:0] pend_val_q, pend_val_d;
    logic [31:0] pend_rep_q, pend_rep_d;
    logic        do_switch, sw_seg, trig, reject_d;
    logic [31:0] sw_rep;
    logic        gpio_hit;

`ifdef MOD_SWAPCHAIN_GPIO_EN
    // GPIO synchroniser, then a registered rising-edge detector
    logic [3:0] gpio_sync_q [SYNC_STAGES];
    logic [3:0] gpio_prev_q, gpio_rise_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) gpio_sync_q[i] <= '0;
            gpio_prev_q <= '0;
            gpio_rise_q <= '0;
        end else begin
            gpio_sync_q[0] <= GPIO_IN;
            for (int i = 1; i < SYNC_STAGES; i++) gpio_sync_q[i] <= gpio_sync_q[i-1];
            gpio_prev_q <= gpio_sync_q[SYNC_STAGES-1];
            gpio_rise_q <= gpio_sync_q[SYNC_STAGES-1] & ~gpio_prev_q;
        end
    end

    assign gpio_hit = gpio_rise_q[pend_val_q[1:0]];
`else
    logic unused_gpio;
    assign unused_gpio = ^{GPIO_IN, SYNC_STAGES[0]};
    assign gpio_hit    = 1'b0;
`endif

    // Trigger evaluation and request handling; a valid UPDATE always beats a trigger
    always_comb begin
        state_d    = state_q;
        pend_seg_d = pend_seg_q;
        pend_val_d = pend_val_q;
        pend_rep_d = pend_rep_q;
        reject_d   = 1'b0;
        do_switch  = 1'b0;
        sw_seg     = pend_seg_q;
        sw_rep     = pend_rep_q;
        trig       = 1'b0;

        case (state_q)
            // a halted sampler never wraps again, so STOP stands in for LOOP_END
            WAIT_IDX:  trig = LOOP_END | stop_q;
            WAIT_TIME: trig = (SYS_TIME >= pend_val_q);
`ifdef MOD_SWAPCHAIN_GPIO_EN
            WAIT_GPIO: trig = gpio_hit;
`endif
            default:   trig = 1'b0;
        endcase

        if (UPDATE && !mode_valid(TRANSITION_MODE)) begin
            reject_d = 1'b1;
        end

        if (UPDATE && mode_valid(TRANSITION_MODE)) begin
            if (TRANSITION_MODE == MODE_IMMEDIATE) begin
                do_switch = 1'b1;
                sw_seg    = REQ_RD_SEGMENT;
                sw_rep    = REP;
                state_d   = RUN;
            end else begin
                pend_seg_d = REQ_RD_SEGMENT;
                pend_val_d = TRANSITION_VALUE;
                pend_rep_d = REP;
                state_d    = mode_state(TRANSITION_MODE);
            end
        end else if (trig) begin
            do_switch = 1'b1;
            state_d   = RUN;
        end
    end

    // Control and pending-request registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= RUN;
            trans_q    <= 1'b0;
            reject_q   <= 1'b0;
            pend_seg_q <= 1'b0;
            pend_val_q <= '0;
            pend_rep_q <= '0;
        end else begin
            state_q    <= state_d;
            trans_q    <= do_switch;
            reject_q   <= reject_d;
            pend_seg_q <= pend_seg_d;
            pend_val_q <= pend_val_d;
            pend_rep_q <= pend_rep_d;
        end
    end

    // Active segment and its loop counter; counting continues while a request is pending
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            seg_q  <= 1'b0;
            stop_q <= 1'b0;
            rep_q  <= REP_INFINITE;
            cnt_q  <= '0;
        end else if (do_switch) begin
            seg_q  <= sw_seg;
            stop_q <= 1'b0;
            rep_q  <= sw_rep;
            cnt_q  <= '0;
        end else if (LOOP_END && !stop_q && (rep_q != REP_INFINITE)) begin
            if (cnt_q == rep_q) begin
                stop_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign SEGMENT    = seg_q;
    assign TRANSITION = trans_q;
    assign STOP       = stop_q;
    assign REJECT     = reject_q;

endmodule

// File: tb/tb_mod_swapchain.sv
// Self-checking bench for mod_swapchain: directed scenarios plus random traffic against a request-level model.
// Compile with +define+MOD_SWAPCHAIN_GPIO_EN to exercise the GPIO transition mode.

module tb_mod_swapchain;

    localparam int SYNC_STAGES = 2;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        UPDATE;
    logic        REQ_RD_SEGMENT;
    logic [7:0]  TRANSITION_MODE;
    logic [63:0] TRANSITION_VALUE;
    logic [31:0] REP;
    logic [63:0] SYS_TIME;
    logic        LOOP_END;
    logic [3:0]  GPIO_IN;
    logic        SEGMENT, TRANSITION, STOP, REJECT;

    mod_swapchain #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .UPDATE           (UPDATE),
        .REQ_RD_SEGMENT   (REQ_RD_SEGMENT),
        .TRANSITION_MODE  (TRANSITION_MODE),
        .TRANSITION_VALUE (TRANSITION_VALUE),
        .REP              (REP),
        .SYS_TIME         (SYS_TIME),
        .LOOP_END         (LOOP_END),
        .GPIO_IN          (GPIO_IN),
        .SEGMENT          (SEGMENT),
        .TRANSITION       (TRANSITION),
        .STOP             (STOP),
        .REJECT           (REJECT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int n_trans  = 0;

    // request-level reference: active segment, loops left before STOP, one pending request
    logic        m_seg, m_trans, m_stop, m_rej;
    logic [31:0] m_rep, m_left;
    logic        m_pending, m_pseg;
    logic [7:0]  m_pmode;
    logic [63:0] m_pval;
    logic [31:0] m_prep;
    logic [3:0]  ghist [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_seg = 1'b0; m_trans = 1'b0; m_stop = 1'b0; m_rej = 1'b0;
        m_rep = 32'hFFFF_FFFF; m_left = '0;
        m_pending = 1'b0; m_pseg = 1'b0; m_pmode = '0; m_pval = '0; m_prep = '0;
        for (int k = 0; k < 16; k++) ghist[k] = '0;
    endfunction

    // advance the reference by one clock using the inputs currently applied
    function automatic void model_step();
        logic        valid, fire, sw, nseg;
        logic [31:0] nrep;
        valid = (TRANSITION_MODE == 8'h00) || (TRANSITION_MODE == 8'h01) || (TRANSITION_MODE == 8'hFF);
`ifdef MOD_SWAPCHAIN_GPIO_EN
        valid = valid || (TRANSITION_MODE == 8'h02);
`endif
        fire = 1'b0;
        if (m_pending) begin
            if (m_pmode == 8'h00)      fire = LOOP_END || m_stop;
            else if (m_pmode == 8'h01) fire = (SYS_TIME >= m_pval);
            else fire = ghist[SYNC_STAGES][m_pval[1:0]] && !ghist[SYNC_STAGES+1][m_pval[1:0]];
        end
        m_rej = UPDATE && !valid;
        sw = 1'b0; nseg = m_seg; nrep = m_rep;
        if (UPDATE && valid) begin
            if (TRANSITION_MODE == 8'hFF) begin
                sw = 1'b1; nseg = REQ_RD_SEGMENT; nrep = REP; m_pending = 1'b0;
            end else begin
                m_pending = 1'b1; m_pmode = TRANSITION_MODE; m_pseg = REQ_RD_SEGMENT;
                m_pval = TRANSITION_VALUE; m_prep = REP;
            end
        end else if (fire) begin
            sw = 1'b1; nseg = m_pseg; nrep = m_prep; m_pending = 1'b0;
        end
        if (sw) begin
            m_seg = nseg; m_rep = nrep; m_left = nrep; m_stop = 1'b0;
        end else if (LOOP_END && !m_stop && m_rep != 32'hFFFF_FFFF) begin
            if (m_left == 0) m_stop = 1'b1;
            else m_left = m_left - 1;
        end
        m_trans = sw;
        for (int k = 15; k > 0; k--) ghist[k] = ghist[k-1];
        ghist[0] = GPIO_IN;
    endfunction

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
        check("segment", SEGMENT, m_seg);
        check("transition", TRANSITION, m_trans);
        check("stop", STOP, m_stop);
        check("reject", REJECT, m_rej);
        if (TRANSITION === 1'b1) n_trans++;
        UPDATE   = 1'b0;
        LOOP_END = 1'b0;
        SYS_TIME = SYS_TIME + 64'd1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_loop_end();
        LOOP_END = 1'b1;
        step();
    endtask

    task automatic req(input logic s, input logic [7:0] m, input logic [63:0] v, input logic [31:0] r);
        UPDATE = 1'b1; REQ_RD_SEGMENT = s; TRANSITION_MODE = m; TRANSITION_VALUE = v; REP = r;
        step();
    endtask

    task automatic mid_cycle_reset();
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        check("async_reset_segment", SEGMENT, 1'b0);
        check("async_reset_stop", STOP, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        logic [7:0] modes [6];
        int         sel;
        modes[0] = 8'h00; modes[1] = 8'h01; modes[2] = 8'hFF;
        modes[3] = 8'h02; modes[4] = 8'h07; modes[5] = 8'h00;

        RESET_N = 1'b0; UPDATE = 1'b0; REQ_RD_SEGMENT = 1'b0; TRANSITION_MODE = '0;
        TRANSITION_VALUE = '0; REP = '0; SYS_TIME = '0; LOOP_END = 1'b0; GPIO_IN = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        check("reset_segment", SEGMENT, 1'b0);
        check("reset_transition", TRANSITION, 1'b0);
        check("reset_stop", STOP, 1'b0);
        check("reset_reject", REJECT, 1'b0);

        // immediate switch, infinite repeat
        req(1'b1, 8'hFF, 64'd0, 32'hFFFF_FFFF);
        check("imm_segment", SEGMENT, 1'b1);
        check("imm_transition", TRANSITION, 1'b1);
        repeat (10) begin pulse_loop_end(); idle(1); end
        check("inf_no_stop", STOP, 1'b0);

        // SYNC_IDX switch then finite repeat of 3 loops
        req(1'b0, 8'h00, 64'd0, 32'd2);
        idle(4);
        check("idx_wait_segment", SEGMENT, 1'b1);
        pulse_loop_end();
        check("idx_segment", SEGMENT, 1'b0);
        check("idx_transition", TRANSITION, 1'b1);
        pulse_loop_end(); idle(1); pulse_loop_end(); idle(1);
        check("stop_before_third", STOP, 1'b0);
        pulse_loop_end();
        check("stop_after_third", STOP, 1'b1);
        pulse_loop_end();
        check("stop_held", STOP, 1'b1);
        check("stop_no_transition", TRANSITION, 1'b0);

        // SYS_TIME thresholds: future and already passed
        SYS_TIME = 64'd990;
        req(1'b1, 8'h01, 64'd1000, 32'hFFFF_FFFF);
        idle(9);
        check("time_before", SEGMENT, 1'b0);
        step();
        check("time_after", SEGMENT, 1'b1);
        check("time_transition", TRANSITION, 1'b1);
        SYS_TIME = 64'd990;
        req(1'b0, 8'h01, 64'd5, 32'hFFFF_FFFF);
        check("past_t1", SEGMENT, 1'b1);
        step();
        check("past_t2", SEGMENT, 1'b0);

        // a newer IMMEDIATE request replaces a pending time request
        req(1'b1, 8'h01, SYS_TIME + 64'd20, 32'hFFFF_FFFF);
        idle(3);
        req(1'b0, 8'hFF, 64'd0, 32'd0);
        check("replace_segment", SEGMENT, 1'b0);
        check("replace_transition", TRANSITION, 1'b1);
        n_trans = 0;
        idle(30);
        check("replace_no_late_switch", n_trans, 0);

        // invalid modes
        req(1'b1, 8'h07, 64'd0, 32'd5);
        check("invalid_reject", REJECT, 1'b1);
        check("invalid_segment", SEGMENT, 1'b0);
        step();
        check("reject_one_cycle", REJECT, 1'b0);
`ifdef MOD_SWAPCHAIN_GPIO_EN
        req(1'b1, 8'h02, 64'd2, 32'hFFFF_FFFF);
        idle(2);
        GPIO_IN = 4'b0100;
        idle(SYNC_STAGES + 1);
        check("gpio_before", SEGMENT, 1'b0);
        step();
        check("gpio_segment", SEGMENT, 1'b1);
        check("gpio_transition", TRANSITION, 1'b1);
        GPIO_IN = 4'b0000;
        idle(2);
`else
        req(1'b1, 8'h02, 64'd2, 32'd5);
        check("gpio_reject", REJECT, 1'b1);
        check("gpio_segment", SEGMENT, 1'b0);
`endif
        req(1'b0, 8'hFF, 64'd0, 32'd0);

        // STOP already set: SYNC_IDX switches without a LOOP_END
        pulse_loop_end();
        check("stop_seg0", STOP, 1'b1);
        req(1'b1, 8'h00, 64'd0, 32'd5);
        check("stopped_t1", SEGMENT, 1'b0);
        step();
        check("stopped_t2", SEGMENT, 1'b1);
        check("stopped_transition", TRANSITION, 1'b1);

        // reset while waiting drops the pending request
        req(1'b0, 8'h00, 64'd0, 32'd5);
        idle(1);
        mid_cycle_reset();
        n_trans = 0;
        repeat (4) begin pulse_loop_end(); idle(1); end
        check("post_reset_segment", SEGMENT, 1'b0);
        check("post_reset_no_switch", n_trans, 0);

        // random traffic
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) begin
                sel = $urandom_range(0, 5);
                UPDATE = 1'b1;
                REQ_RD_SEGMENT = 1'($urandom_range(0, 1));
                TRANSITION_MODE = modes[sel];
                TRANSITION_VALUE = (modes[sel] == 8'h01) ? SYS_TIME + 64'($urandom_range(0, 25))
                                                         : 64'($urandom_range(0, 3));
                REP = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3));
            end
            LOOP_END = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) GPIO_IN = 4'($urandom_range(0, 15));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
